// File: rtl/comparator_1bit.sv
// Registered one-bit magnitude comparator with MSB-first bit-serial chaining.
// The result register is a one-hot GT/EQ/LT code that drives the outputs directly.
module comparator_1bit (
    input  logic clk,
    input  logic rst,
    input  logic A_in,
    input  logic B_in,
    input  logic in_valid,
    input  logic frame_start,
    output logic is_greater,
    output logic is_equal,
    output logic is_less,
    output logic out_valid
);

    typedef enum logic [2:0] {
        RES_GT = 3'b100,
        RES_EQ = 3'b010,
        RES_LT = 3'b001
    } res_t;

    res_t r_res;
    res_t w_res_next;
    logic r_out_valid;

    function automatic res_t bit_decision(input logic a, input logic b);
        res_t d;
        case ({a, b})
            2'b10:   d = RES_GT;
            2'b01:   d = RES_LT;
            2'b00:   d = RES_EQ;
            2'b11:   d = RES_EQ;
            default: d = RES_EQ;
        endcase
        return d;
    endfunction

    // Next result: a frame start or an undecided (EQ) result takes the new bit,
    // a decided result holds; any non-one-hot code recovers to a legal one.
    always_comb begin
        w_res_next = r_res;
        if (in_valid) begin
            case (r_res)
                RES_EQ:         w_res_next = bit_decision(A_in, B_in);
                RES_GT, RES_LT: w_res_next = frame_start ? bit_decision(A_in, B_in) : r_res;
                default:        w_res_next = bit_decision(A_in, B_in);
            endcase
        end else begin
            case (r_res)
                RES_EQ, RES_GT, RES_LT: w_res_next = r_res;
                default:                w_res_next = RES_EQ;
            endcase
        end
    end

    // Result and valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res       <= RES_EQ;
            r_out_valid <= 1'b0;
        end else begin
            r_res       <= w_res_next;
            r_out_valid <= in_valid;
        end
    end

    assign is_greater = r_res[2];
    assign is_equal   = r_res[1];
    assign is_less    = r_res[0];
    assign out_valid  = r_out_valid;

endmodule

// File: tb/tb_comparator_1bit.sv
// Self-checking bench: directed scenarios plus random bit streams checked against
// a model that accumulates each frame as integers and compares them numerically.
module tb_comparator_1bit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic A_in = 1'b0;
    logic B_in = 1'b0;
    logic in_valid = 1'b0;
    logic frame_start = 1'b0;
    logic is_greater;
    logic is_equal;
    logic is_less;
    logic out_valid;

    int n_checks = 0;
    int n_pass = 0;

    longint unsigned m_wa = 64'd0;
    longint unsigned m_wb = 64'd0;
    int              m_len = 0;
    logic            m_ov = 1'b0;

    comparator_1bit dut (
        .clk         (clk),
        .rst         (rst),
        .A_in        (A_in),
        .B_in        (B_in),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .is_greater  (is_greater),
        .is_equal    (is_equal),
        .is_less     (is_less),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check_result(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_checks++;
        if (obs !== exp_v)
            $display("FAIL %s: got gt/eq/lt/ov=%b, expected %b", tag, obs, exp_v);
        else
            n_pass++;
    endtask

    function automatic logic [3:0] model_vec();
        return {m_wa > m_wb, m_wa == m_wb, m_wa < m_wb, m_ov};
    endfunction

    function automatic logic [3:0] dut_vec();
        return {is_greater, is_equal, is_less, out_valid};
    endfunction

    task automatic model_reset();
        m_wa = 64'd0;
        m_wb = 64'd0;
        m_len = 0;
        m_ov = 1'b0;
    endtask

    task automatic model_accept(input logic v, input logic fs, input logic a, input logic b);
        if (v) begin
            if (fs) begin
                m_wa = longint'(a);
                m_wb = longint'(b);
                m_len = 1;
            end else begin
                m_wa = (m_wa << 1) + longint'(a);
                m_wb = (m_wb << 1) + longint'(b);
                m_len++;
            end
            m_ov = 1'b1;
        end else begin
            m_ov = 1'b0;
        end
    endtask

    // Called at a falling edge; drives, clocks, then checks at the next falling edge.
    task automatic step(input logic v, input logic fs, input logic a, input logic b, input string tag);
        in_valid = v;
        frame_start = fs;
        A_in = a;
        B_in = b;
        @(posedge clk);
        model_accept(v, fs, a, b);
        @(negedge clk);
        check_result(tag, dut_vec(), model_vec());
    endtask

    // Called at a falling edge; asserts reset between edges and releases it at the next falling edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_result(tag, dut_vec(), model_vec());
        check_result({tag, "_const"}, dut_vec(), 4'b0100);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic v;
        logic fs;
        logic a;
        logic b;

        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_result("reset_async", dut_vec(), 4'b0100);
        @(negedge clk);
        rst = 1'b0;

        step(1'b1, 1'b1, 1'b0, 1'b0, "sweep_00");
        check_result("sweep_00_const", dut_vec(), 4'b0101);
        step(1'b1, 1'b1, 1'b0, 1'b1, "sweep_01");
        check_result("sweep_01_const", dut_vec(), 4'b0011);
        step(1'b1, 1'b1, 1'b1, 1'b0, "sweep_10");
        check_result("sweep_10_const", dut_vec(), 4'b1001);
        step(1'b1, 1'b1, 1'b1, 1'b1, "sweep_11");
        check_result("sweep_11_const", dut_vec(), 4'b0101);

        step(1'b1, 1'b1, 1'b1, 1'b1, "word1_b3");
        step(1'b1, 1'b0, 1'b0, 1'b0, "word1_b2");
        step(1'b1, 1'b0, 1'b1, 1'b0, "word1_b1");
        step(1'b1, 1'b0, 1'b1, 1'b1, "word1_b0");
        check_result("word1_final", dut_vec(), 4'b1001);

        step(1'b1, 1'b1, 1'b0, 1'b0, "word2_b3");
        step(1'b1, 1'b0, 1'b1, 1'b1, "word2_b2");
        step(1'b0, 1'b0, 1'b1, 1'b0, "word2_gap0");
        check_result("word2_gap0_const", dut_vec(), 4'b0100);
        step(1'b0, 1'b1, 1'b0, 1'b1, "word2_gap1");
        step(1'b1, 1'b0, 1'b1, 1'b1, "word2_b1");
        step(1'b1, 1'b0, 1'b0, 1'b1, "word2_b0");
        check_result("word2_final", dut_vec(), 4'b0011);

        step(1'b1, 1'b1, 1'b1, 1'b0, "hold_gt");
        step(1'b1, 1'b0, 1'b0, 1'b1, "hold_keep");
        check_result("hold_keep_const", dut_vec(), 4'b1001);
        step(1'b1, 1'b1, 1'b0, 1'b1, "hold_override");
        check_result("hold_override_const", dut_vec(), 4'b0011);

        step(1'b1, 1'b1, 1'b0, 1'b1, "midrst_b3");
        step(1'b1, 1'b0, 1'b1, 1'b1, "midrst_b2");
        async_reset("midrst_reset");
        step(1'b1, 1'b0, 1'b1, 1'b0, "midrst_resume");
        check_result("midrst_resume_const", dut_vec(), 4'b1001);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                async_reset("rand_reset");
            end
            v  = ($urandom_range(3) != 0);
            fs = ($urandom_range(5) == 0) || (m_len >= 60);
            a  = 1'($urandom_range(1));
            b  = 1'($urandom_range(1));
            step(v, fs, a, b, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/comparator_1bit.md
# comparator_1bit

Registered one-bit magnitude comparator with optional MSB-first bit-serial chaining. Each valid cycle it compares `A_in` against `B_in` and drives a one-hot greater/equal/less result. With `frame_start` asserted on every valid cycle it acts as a plain single-bit comparator. With `frame_start` asserted only on the first bit, it compares multi-bit words streamed MSB first. It sits at the leaves of compare and sort datapaths that need a registered, glitch-free decision.

## Interface
- No parameters.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `A_in`  input  1  operand A bit; sampled only when `in_valid`=1.
- `B_in`  input  1  operand B bit; sampled only when `in_valid`=1.
- `in_valid`  input  1  qualifies `A_in`/`B_in`/`frame_start` this cycle.
- `frame_start`  input  1  marks the first (MSB) bit of a new comparison; ignored when `in_valid`=0.
- `is_greater`  output  1  registered; 1 when A > B so far.
- `is_equal`  output  1  registered; 1 when A == B so far.
- `is_less`  output  1  registered; 1 when A < B so far.
- `out_valid`  output  1  registered; 1 for exactly the cycle after each accepted input.

## Operation
- Per-bit decision: GT = A & ~B; LT = ~A & B; EQ = ~(A ^ B).
- Accepted cycle with `in_valid`=1 and `frame_start`=1:
  - Result registers load the per-bit decision.
  - Prior history is discarded.
- Accepted cycle with `in_valid`=1 and `frame_start`=0:
  - If the current result is EQ, load the per-bit decision.
  - If the current result is GT or LT, hold it. The first differing bit, MSB first, decides.
- `in_valid`=1 with `frame_start`=0 directly after reset behaves like a continuation from EQ, which is equivalent to a frame start.
- Cycle with `in_valid`=0: result registers hold their value; `out_valid` goes to 0.
- The outputs are strictly one-hot at all times, including during and after reset.
- There is no backpressure: every valid cycle is accepted.
- `out_valid` is not gated by frame completion. The consumer knows the word length and reads the result on the `out_valid` following the LSB.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and are stable throughout cycle N+1.
- Back-to-back valid inputs give back-to-back `out_valid` pulses at full throughput.
- Reset values: `is_greater`=0, `is_equal`=1, `is_less`=0, `out_valid`=0.
- Reset takes effect immediately and asynchronously, independent of `clk`.
- Deassertion of `rst` is synchronised externally. The first edge after deassertion may accept input.
- Reset mid-frame aborts the frame and forces the reset values. The next accepted bit behaves as a frame start.
- `frame_start`=1 while a decision is held (GT or LT) overrides the hold on that same edge.
- `in_valid`=0 cycles inside a frame are allowed. The frame resumes on the next valid bit.

## Test plan
- Reset: assert `rst` asynchronously between edges, with no clock edge. The outputs go to gt/eq/lt=0/1/0 and `out_valid`=0 immediately.
- Single-bit sweep with `frame_start`=1 and `in_valid`=1, driving (A,B)=00, 01, 10, 11 on successive edges. The next-cycle outputs are gt/eq/lt = 010, 001, 100, 010, with `out_valid`=1 each cycle.
- Serial word A=1011 vs B=1001 (MSB first, `frame_start` on the first bit). The results after each bit are EQ, EQ, GT, GT; the final result is GT.
- Serial word A=0110 vs B=0111 with a two-cycle `in_valid`=0 gap after bit 2. During the gap, `out_valid`=0 and EQ is held; the final result is LT.
- Decision hold and override: with GT held mid-frame, a bit with A=0, B=1 and `frame_start`=0 keeps GT. The same bit with `frame_start`=1 gives LT.
- Reset mid-frame: assert `rst` after 2 bits of an LT-decided frame. The outputs show EQ and `out_valid`=0. After release, a bit with A=1, B=0 and `frame_start`=0 gives GT.
